// File: rtl/seq_pkg.sv
// Shared types and constants for the channel enable sequencer.
// Status word places the active flags in the low half and the latched faults in the high half.
package seq_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } seq_state_t;

  localparam int unsigned NCH_MAX         = 16;
  localparam int unsigned STAT_ACTIVE_LSB = 0;
  localparam int unsigned STAT_FAULT_LSB  = 16;

endpackage

// File: rtl/channel_fault_latch.sv
// Per-channel fault capture: 2-flop synchronizer into a sticky latch.
// The host clears the latch by dropping the channel's enable once the fault has gone.
module channel_fault_latch (
  input  logic clock,
  input  logic reset,
  input  logic fault,
  input  logic enable,
  output logic latched
);

  logic sync1;
  logic sync2;

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      latched <= 1'b0;
    end else begin
      sync1 <= fault;
      sync2 <= sync1;
      // Set has priority over clear.
      if (sync2) begin
        latched <= 1'b1;
      end else if (!enable) begin
        latched <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/channel_enable_sequencer.sv
// Powers channels up one at a time (lowest index first) with a settle interval between them;
// powers them down immediately on disable or latched fault.
module channel_enable_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned NCH           = 16,
  parameter int unsigned SETTLE_CYCLES = 1000
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [31:0]    channels_enable,
  input  logic [NCH-1:0] channel_fault,
  output logic [NCH-1:0] channel_drive,
  output logic [31:0]    channels_status,
  output logic           busy
);

  localparam int unsigned IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);

  seq_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] cur;
  logic [IDX_W-1:0] cur_next;
  logic             found;
  logic [NCH-1:0]   active;
  logic [NCH-1:0]   flt_l;
  logic [NCH-1:0]   en;
  logic [NCH-1:0]   off;
  logic [NCH-1:0]   pend;
  logic             unused_enable_bits;

  assign en   = channels_enable[NCH-1:0];
  assign off  = ~en | flt_l;
  assign pend = en & ~channel_drive & ~flt_l;

  generate
    if (NCH < 32) begin : g_unused
      assign unused_enable_bits = ^channels_enable[31:NCH];
    end else begin : g_no_unused
      assign unused_enable_bits = 1'b0;
    end
  endgenerate

  for (genvar g = 0; g < NCH; g++) begin : g_flt
    channel_fault_latch u_latch (
      .clock   (clock),
      .reset   (reset),
      .fault   (channel_fault[g]),
      .enable  (channels_enable[g]),
      .latched (flt_l[g])
    );
  end

  // Lowest pending index wins.
  always_comb begin
    cur_next = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (pend[i] && !found) begin
        cur_next = IDX_W'(i);
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      cur           <= '0;
      channel_drive <= '0;
      active        <= '0;
      busy          <= 1'b0;
    end else begin
      // Power-down runs regardless of the FSM; the FSM only ever raises bits that are not off.
      channel_drive <= channel_drive & ~off;
      active        <= active & ~off;
      busy          <= (state == SETTLE);
      case (state)
        IDLE: begin
          if (found) begin
            cur                     <= cur_next;
            channel_drive[cur_next] <= 1'b1;
            cnt                     <= CNT_W'(SETTLE_CYCLES - 1);
            state                   <= SETTLE;
          end
        end
        SETTLE: begin
          if (off[cur]) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            active[cur] <= 1'b1;
            state       <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    channels_status                             = '0;
    channels_status[STAT_ACTIVE_LSB +: NCH]     = active;
    channels_status[STAT_FAULT_LSB +: NCH]      = flt_l;
  end

endmodule

// File: tb/tb_channel_enable_sequencer.sv
// Directed bench for channel_enable_sequencer with NCH=4, SETTLE_CYCLES=4.
module tb_channel_enable_sequencer;

  logic        clock;
  logic        reset;
  logic [31:0] channels_enable;
  logic [3:0]  channel_fault;
  logic [3:0]  channel_drive;
  logic [31:0] channels_status;
  logic        busy;

  int unsigned n_cmp;
  int unsigned n_err;

  channel_enable_sequencer #(
    .NCH           (4),
    .SETTLE_CYCLES (4)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .channels_enable (channels_enable),
    .channel_fault   (channel_fault),
    .channel_drive   (channel_drive),
    .channels_status (channels_status),
    .busy            (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one active edge and settle at the following falling edge.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  function automatic logic [31:0] drv(input logic [3:0] d);
    return {28'b0, d};
  endfunction

  initial begin
    logic [3:0]  exp_drv;
    logic [31:0] exp_st;
    logic        exp_busy;
    int unsigned n;

    n_cmp           = 0;
    n_err           = 0;
    reset           = 1'b0;
    channels_enable = 32'hF;
    channel_fault   = '0;
    @(negedge clock);

    // 1: reset holds everything low even with all channels requested
    for (int c = 0; c < 3; c++) begin
      step();
      check("rst_drive",  drv(channel_drive), 32'h0);
      check("rst_status", channels_status,    32'h0);
      check("rst_busy",   {31'b0, busy},      32'h0);
    end

    // 2: staggered power-up of channels 0 and 2; edge 0 is the first edge after release
    reset           = 1'b1;
    channels_enable = 32'h5;
    for (int e = 0; e <= 10; e++) begin
      step();
      exp_drv  = (e >= 5) ? 4'b0101 : 4'b0001;
      exp_st   = (e >= 9) ? 32'h5 : (e >= 4) ? 32'h1 : 32'h0;
      exp_busy = ((e >= 1) && (e <= 4)) || ((e >= 6) && (e <= 9));
      check("pwrup_drive",  drv(channel_drive), drv(exp_drv));
      check("pwrup_status", channels_status,    exp_st);
      check("pwrup_busy",   {31'b0, busy},      {31'b0, exp_busy});
    end

    // 3: abort mid-settle
    channels_enable = 32'h0;
    step();
    check("clr_drive", drv(channel_drive), 32'h0);
    channels_enable = 32'h1;
    step();                                   // edge 0
    check("abort_drive_e0", drv(channel_drive), 32'h1);
    step();                                   // edge 1
    channels_enable = 32'h0;
    step();                                   // edge 2
    check("abort_drive_e2", drv(channel_drive), 32'h0);
    check("abort_busy_e2",  {31'b0, busy},      32'h1);
    step();                                   // edge 3
    check("abort_busy_e3",  {31'b0, busy},      32'h0);
    for (int e = 4; e <= 8; e++) begin
      step();
      check("abort_status", channels_status,    32'h0);
      check("abort_drive",  drv(channel_drive), 32'h0);
    end

    // 4: fault on an active channel
    channels_enable = 32'hF;
    for (int e = 0; e <= 19; e++) step();
    check("all_drive",  drv(channel_drive), 32'hF);
    check("all_status", channels_status,    32'h0000_000F);
    channel_fault = 4'b0010;                  // high before edge k
    step();                                   // edge k
    channel_fault = 4'b0000;
    step();                                   // edge k+1
    check("flt_k1_status", channels_status, 32'h0000_000F);
    step();                                   // edge k+2: latch set, drive still high
    check("flt_k2_status", channels_status,    32'h0002_000F);
    check("flt_k2_drive",  drv(channel_drive), 32'hF);
    step();                                   // edge k+3
    check("flt_k3_drive",  drv(channel_drive), 32'hD);
    check("flt_k3_status", channels_status,    32'h0002_000D);
    for (int c = 0; c < 6; c++) step();
    check("flt_hold_status", channels_status,    32'h0002_000D);
    check("flt_hold_drive",  drv(channel_drive), 32'hD);

    // 5: clear fault and retry channel 1
    channels_enable = 32'hD;
    step();                                   // edge m
    check("fclr_status", channels_status, 32'h0000_000D);
    channels_enable = 32'hF;
    step();                                   // edge m+1
    check("retry_drive", drv(channel_drive), 32'hF);
    for (int c = 0; c < 3; c++) step();       // edge m+4
    check("retry_status_m4", channels_status, 32'h0000_000D);
    step();                                   // edge m+5
    check("retry_status_m5", channels_status, 32'h0000_000F);

    // 6: reset while channel 2 is settling
    channels_enable = 32'h0;
    step();
    check("clr2_status", channels_status, 32'h0);
    channels_enable = 32'hF;
    for (int e = 0; e <= 11; e++) step();     // ch0,1 active, ch2 driven at edge 10
    check("pre_rst_drive",  drv(channel_drive), 32'h7);
    check("pre_rst_status", channels_status,    32'h3);
    reset = 1'b0;
    step();
    check("midrst_drive",  drv(channel_drive), 32'h0);
    check("midrst_status", channels_status,    32'h0);
    check("midrst_busy",   {31'b0, busy},      32'h0);
    reset = 1'b1;
    for (int e = 0; e <= 19; e++) begin
      step();
      n       = (e / 5) + 1;
      exp_drv = 4'((32'd1 << n) - 1);
      exp_st  = '0;
      for (int i = 0; i < 4; i++) begin
        if (e >= 5 * i + 4) exp_st[i] = 1'b1;
      end
      check("reseq_drive",  drv(channel_drive), drv(exp_drv));
      check("reseq_status", channels_status,    exp_st);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/channel_enable_sequencer.md
# channel_enable_sequencer

Consumes the `channels_enable` word held by the register block and drives the per-channel enable outputs. Channels power up one at a time, lowest index first, with a fixed settle interval between them to limit inrush current. Channels power down immediately. Per-channel faults are latched and reported back to the register block through `channels_status`, where host reads return them.

## Interface
Parameters:
- `NCH`, default 16: number of channels; legal range 1..16.
- `SETTLE_CYCLES`, default 1000: settle interval per channel in clock cycles; must be ≥1.

Ports:
- `clock`, in, 1: single clock for the whole block.
- `reset`, in, 1: synchronous, active-low reset.
- `channels_enable`, in, 32: requested enable word from the register block.
  - Bit i requests channel i, for i < NCH.
  - Bits [31:NCH] are ignored.
- `channel_fault`, in, NCH: asynchronous per-channel fault flags, active-high.
- `channel_drive`, out, NCH: per-channel enable to the hardware.
- `channels_status`, out, 32: status word to the register block.
  - [NCH-1:0] = channel active, meaning settled and healthy.
  - [16+NCH-1:16] = fault latched.
  - All other bits read 0.
- `busy`, out, 1: high while a settle interval is running.

## Operation
- **Fault synchronizer:** `channel_fault` passes through a 2-flop synchronizer, producing `flt_s`.
- **Fault latch `flt_l[i]`:**
  - Sets when `flt_s[i]`=1.
  - Clears only when `flt_s[i]`=0 and `channels_enable[i]`=0. The host clears a fault by writing the enable bit to 0.
  - Set has priority over clear.
- **Pending vector:** `pend = channels_enable[NCH-1:0] & ~channel_drive & ~flt_l`.
- **Power-down (independent of the FSM):** if `channels_enable[i]`=0 or `flt_l[i]`=1, then `channel_drive[i]` and `active[i]` clear on the next edge.
- **FSM states `IDLE` and `SETTLE`:**
  - `IDLE`: if `pend`≠0, select `cur` = lowest set index. Then `channel_drive[cur]`<=1, `cnt`<=SETTLE_CYCLES-1, go to `SETTLE`.
  - `SETTLE`, abort case: if `cur` is powered down this cycle (enable low or fault latched), go to `IDLE` and leave `active[cur]` at 0.
  - `SETTLE`, completion: else if `cnt`==0, `active[cur]`<=1 and go to `IDLE`.
  - `SETTLE`, otherwise: `cnt`<=`cnt`-1.
- **Late requests:** enable bits that rise during `SETTLE` stay pending. They are served in index order after the FSM returns to `IDLE`.
- **`busy`:** equals (state==`SETTLE`), as a registered output.
- **Counter width:** `$clog2(SETTLE_CYCLES+1)`. The counter never underflows.
- **Reset values:**
  - `channel_drive`=0, `channels_status`=0, `busy`=0, state=`IDLE`, `cnt`=0.
  - Synchronizer flops and `flt_l` = 0.
- **Reset mid-settle:** all drives drop on the reset edge. After `reset` deasserts, channels re-sequence from the lowest index.

## Timing
- Enable bit i rises, is sampled at edge k, and the FSM is in `IDLE` → `channel_drive[i]`=1 after edge k.
- `active[i]`=1 after edge k+SETTLE_CYCLES.
- The next pending channel's drive rises after edge k+SETTLE_CYCLES+1.
- Disable: enable bit i falls, sampled at edge k → `channel_drive[i]`=0 and `active[i]`=0 after edge k.
- Fault path:
  - `channel_fault[i]` high before edge k → `flt_s` high after edge k+1.
  - `flt_l[i]` high after edge k+2.
  - `channel_drive[i]` and `active[i]` low after edge k+3.
- Simultaneous requests: at most one channel is started per `IDLE` cycle. Lowest index wins.
- Simultaneous set and clear of `flt_l`: set wins.
- Outputs are registered. There is no combinational path from input to output.

## Structure
- Shared package `seq_pkg` holds:
  - the state enum `seq_state_t` {`IDLE`, `SETTLE`};
  - `NCH_MAX`=16;
  - status-word field offsets `STAT_ACTIVE_LSB`=0 and `STAT_FAULT_LSB`=16.
- Sub-module `channel_fault_latch`, instantiated NCH times: the 2-flop synchronizer plus `flt_l` with its set/clear logic.
- The top level holds the FSM, counter, priority encoder and drive/active registers.

## Test plan
Bench parameters: NCH=4, SETTLE_CYCLES=4.

1. **Reset:** hold `reset`=0 for 3 cycles with `channels_enable`=32'hF → `channel_drive`=0, `channels_status`=0, `busy`=0 throughout.
2. **Staggered power-up:** after reset, `channels_enable`=32'h5 at edge 0:
   - `drive[0]` rises after edge 0, `status[0]` after edge 4.
   - `drive[2]` rises after edge 5, `status[2]` after edge 9.
   - Final `channels_status`=32'h5.
3. **Abort mid-settle:** enable 32'h1, then at edge 2 write 32'h0 → drive[0]=0 after edge 2, `busy`=0 after edge 3, `status[0]` never set.
4. **Fault on active channel:** all 4 channels active, pulse `channel_fault[1]` before edge k → after edge k+3, drive=4'b1101 and `channels_status`=32'h0002_000D. Fault stays latched while `enable[1]`=1.
5. **Fault clear and retry:** from scenario 4 with the fault removed, write 32'hD then 32'hF.
   - The write of 32'hD clears `status[17]`.
   - Channel 1 re-sequences and `channels_status` returns to 32'h0000_000F.
6. **Reset mid-settle:** assert `reset` during settling of channel 2 with channels 0 and 1 active → all outputs 0 next edge. After release, the channels re-sequence in order 0,1,2,3 at 5-cycle spacing.
